// File: rtl/rv32imf_rr_arbiter_pkg.sv
// Shared types for the rv32imf round-robin arbiter slice.
// Holds the lock-state encoding used by the zero-latency arbitration path.
package rv32imf_rr_arbiter_pkg;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rv32imf_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i, plus an all-zero flag.
// first_one_o is 0 when no bit is set.
module rv32imf_ff_one #(
   parameter  int unsigned LEN  = 4,
   localparam int unsigned IdxW = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic [LEN-1:0]  in_i,
   output logic [IdxW-1:0] first_one_o,
   output logic            no_ones_o
);

   // Scan from the top so the lowest set index is written last and wins.
   always_comb begin
      first_one_o = '0;
      for (int unsigned i = LEN; i > 0; i--) begin
         if (in_i[i-1]) first_one_o = IdxW'(i - 1);
      end
   end

   assign no_ones_o = ~|in_i;

endmodule

// File: rtl/rv32imf_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready port among NumReq requesters.
// Optional macro RV32IMF_RR_ARB_OUT_REG_EN adds a one-entry output register.
module rv32imf_rr_arbiter
   import rv32imf_rr_arbiter_pkg::*;
#(
   parameter  int unsigned NumReq    = 4,
   parameter  int unsigned DataWidth = 32,
   localparam int unsigned IdxW      = $clog2(NumReq)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [NumReq-1:0]                 req_i,
   input  logic [NumReq-1:0][DataWidth-1:0]  data_i,
   output logic [NumReq-1:0]                 gnt_o,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic [DataWidth-1:0]              data_o,
   output logic [IdxW-1:0]                   idx_o
);

   typedef logic [IdxW-1:0] req_idx_t;

   req_idx_t              r_last;
   logic [NumReq-1:0]     w_mask;
   logic [NumReq-1:0]     w_masked;
   req_idx_t              w_sel_m;
   req_idx_t              w_sel_u;
   req_idx_t              w_sel;
   logic                  w_none_m;
   logic                  w_none_u;
   logic                  w_any;

   logic                  w_gnt_en;
   req_idx_t              w_gnt_idx;
   logic                  w_out_valid;
   req_idx_t              w_out_idx;
   logic [DataWidth-1:0]  w_out_data;

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         w_mask[i] = (i > 32'(r_last));
      end
   end

   assign w_masked = req_i & w_mask;

   rv32imf_ff_one #(
      .LEN (NumReq)
   ) u_ff_masked (
      .in_i        (w_masked),
      .first_one_o (w_sel_m),
      .no_ones_o   (w_none_m)
   );

   rv32imf_ff_one #(
      .LEN (NumReq)
   ) u_ff_all (
      .in_i        (req_i),
      .first_one_o (w_sel_u),
      .no_ones_o   (w_none_u)
   );

   assign w_sel = w_none_m ? w_sel_u : w_sel_m;
   assign w_any = ~w_none_u;

`ifndef RV32IMF_RR_ARB_OUT_REG_EN

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   req_idx_t   r_lock_idx;
   logic       w_locked;
   req_idx_t   w_idx;
   logic       w_hs;
   logic       w_stall;

   assign w_idx   = w_locked ? r_lock_idx : w_sel;
   // A flushed cycle is neither a handshake nor a stall.
   assign w_hs    = w_any &  ready_i & ~flush_i;
   assign w_stall = w_any & ~ready_i & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ARB_FREE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush_i)      w_state_nxt = ARB_FREE;
      else if (w_stall) w_state_nxt = ARB_LOCKED;
      else if (w_hs)    w_state_nxt = ARB_FREE;
   end

   always_comb begin
      w_locked = (r_state == ARB_LOCKED);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock_idx <= '0;
         r_last     <= req_idx_t'(NumReq - 1);
      end else begin
         if (w_stall) r_lock_idx <= w_idx;
         if (w_hs)    r_last     <= w_idx;
      end
   end

   assign w_gnt_en    = w_hs;
   assign w_gnt_idx   = w_idx;
   assign w_out_valid = w_any;
   assign w_out_idx   = w_idx;
   assign w_out_data  = data_i[w_idx];

`else

   logic                 r_out_valid;
   logic [DataWidth-1:0] r_out_data;
   req_idx_t             r_out_idx;
   logic                 w_can_load;
   logic                 w_grant;

   assign w_can_load = ~r_out_valid | ready_i;
   assign w_grant    = w_any & w_can_load & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_last      <= req_idx_t'(NumReq - 1);
      end else if (flush_i) begin
         r_out_valid <= 1'b0;
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= data_i[w_sel];
         r_out_idx   <= w_sel;
         r_last      <= w_sel;
      end else if (ready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   assign w_gnt_en    = w_grant;
   assign w_gnt_idx   = w_sel;
   assign w_out_valid = r_out_valid;
   assign w_out_idx   = r_out_idx;
   assign w_out_data  = r_out_data;

`endif

   // Outputs are forced idle while reset is asserted, even with requests pending.
   always_comb begin
      gnt_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         gnt_o[i] = rst_ni & w_gnt_en & (w_gnt_idx == req_idx_t'(i));
      end
   end

   assign valid_o = rst_ni & w_out_valid;
   assign idx_o   = rst_ni ? w_out_idx  : '0;
   assign data_o  = rst_ni ? w_out_data : '0;

endmodule

// File: tb/tb_rv32imf_rr_arbiter.sv
// Scoreboard bench for rv32imf_rr_arbiter with an independent rotating-priority model.
// Covers the base mode and, when RV32IMF_RR_ARB_OUT_REG_EN is defined, the registered mode.
module tb_rv32imf_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 2;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     flush_i;
   logic [N-1:0]             req_i;
   logic [N-1:0][DW-1:0]     data_i;
   logic [N-1:0]             gnt_o;
   logic                     valid_o;
   logic                     ready_i;
   logic [DW-1:0]            data_o;
   logic [IW-1:0]            idx_o;

   typedef struct packed {
      logic          valid;
      logic [N-1:0]  gnt;
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
      logic          chk_idx;
   } exp_t;

   exp_t         sb[$];
   int           n_checks = 0;
   int           n_errors = 0;

   int unsigned  m_last;
   logic         m_lock;
   int unsigned  m_lock_idx;
   logic         m_ov;
   int unsigned  m_oidx;
   logic [N-1:0] pend;

   always #5 clk_i = ~clk_i;

   rv32imf_rr_arbiter #(
      .NumReq    (N),
      .DataWidth (DW)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .req_i   (req_i),
      .data_i  (data_i),
      .gnt_o   (gnt_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .idx_o   (idx_o)
   );

   for (genvar g = 0; g < N; g++) begin : g_req_rule
      a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (req_i[g] && !gnt_o[g]) |=> (req_i[g] && $stable(data_i[g])));
   end

   function automatic logic [DW-1:0] dat(input int unsigned i);
      return 32'hC0DE_0000 | (i << 8) | (i ^ 32'h5A);
   endfunction

   // Next requester after 'last' in circular order.
   function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned last);
      for (int unsigned k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last     = N - 1;
      m_lock     = 1'b0;
      m_lock_idx = 0;
      m_ov       = 1'b0;
      m_oidx     = 0;
   endtask

   task automatic cycle(input logic [N-1:0] want, input logic rdy, input logic fl, input logic rst);
      exp_t        e;
      exp_t        got;
      int unsigned sel;
      logic        grant;
      @(negedge clk_i);
      rst_ni  = rst;
      ready_i = rdy;
      flush_i = fl;
      req_i   = want | pend;
      e = '0;
      sel = rr_pick(req_i, m_last);
      grant = 1'b0;
      if (!rst) begin
         e.chk_idx = 1'b1;
      end else begin
`ifndef RV32IMF_RR_ARB_OUT_REG_EN
         e.valid   = |req_i;
         e.idx     = IW'(m_lock ? m_lock_idx : sel);
         e.data    = dat(e.idx);
         e.gnt     = (e.valid && rdy && !fl) ? (N'(1) << e.idx) : '0;
         e.chk_idx = e.valid;
`else
         grant     = (|req_i) && (!m_ov || rdy) && !fl;
         e.valid   = m_ov;
         e.idx     = IW'(m_oidx);
         e.data    = dat(m_oidx);
         e.gnt     = grant ? (N'(1) << sel) : '0;
         e.chk_idx = m_ov;
`endif
      end
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      check("valid_o", 64'(valid_o), 64'(got.valid));
      check("gnt_o", 64'(gnt_o), 64'(got.gnt));
      if (got.chk_idx) begin
         check("idx_o", 64'(idx_o), 64'(got.idx));
         check("data_o", 64'(data_o), 64'(got.data));
      end
      if (!rst) begin
         model_reset();
         pend = req_i;
      end else begin
`ifndef RV32IMF_RR_ARB_OUT_REG_EN
         if (fl) begin
            m_lock = 1'b0;
         end else if (e.valid && !rdy) begin
            m_lock     = 1'b1;
            m_lock_idx = e.idx;
         end else if (e.valid && rdy) begin
            m_lock = 1'b0;
            m_last = e.idx;
         end
`else
         if (fl) begin
            m_ov = 1'b0;
         end else if (grant) begin
            m_ov   = 1'b1;
            m_oidx = sel;
            m_last = sel;
         end else if (rdy) begin
            m_ov = 1'b0;
         end
`endif
         pend = req_i & ~e.gnt;
      end
   endtask

   initial begin
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      req_i   = '0;
      pend    = '0;
      for (int unsigned i = 0; i < N; i++) data_i[i] = dat(i);
      model_reset();

      // Reset and idle
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Full rotation with wrap
      repeat (5) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
      repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Masked pick then fallback to the unmasked group
      cycle(4'b0010, 1'b1, 1'b0, 1'b1);
      cycle(4'b0101, 1'b1, 1'b0, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Back-pressure lock, higher-priority request arrives while stalled
      repeat (3) cycle(4'b0100, 1'b0, 1'b0, 1'b1);
      cycle(4'b0101, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Flush while locked
      cycle(4'b1000, 1'b0, 1'b0, 1'b1);
      cycle(4'b1010, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, 1'b0, 1'b1, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Reset during a lock
      cycle(4'b1000, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, 1'b1, 1'b0, 1'b1);
      repeat (5) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
      repeat (4) cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      // Single requester back-to-back
      repeat (4) cycle(4'b0100, 1'b1, 1'b0, 1'b1);

      // Random traffic
      repeat (120) begin
         cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 15) == 0), 1'b1);
      end
      repeat (8) cycle(4'b0000, 1'b1, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
